// File: rtl/char_buf_pkg.sv
// Shared widths, defaults, glyph codes and FSM encoding for the character screen buffer.
package char_buf_pkg;

    localparam int unsigned ROWS_DEF = 7;
    localparam int unsigned COLS_DEF = 20;
    localparam int unsigned CELLS    = ROWS_DEF * COLS_DEF;

    localparam int unsigned GLYPH_W = 8;
    localparam int unsigned ROW_W   = 4;
    localparam int unsigned COL_W   = 6;
    localparam int unsigned ADDR_W  = 8;

    localparam logic [GLYPH_W-1:0] BLANK_GLYPH = 8'd128;
    localparam logic [GLYPH_W-1:0] CLR_GLYPH   = 8'hFF;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    typedef struct packed {
        logic               we;
        logic [ADDR_W-1:0]  addr;
        logic [GLYPH_W-1:0] data;
    } ram_wr_t;

    // Linear cell address; 8 bits is enough for every legal row/col pair.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col,
                                                    input int unsigned      cols);
        return ADDR_W'(row) * ADDR_W'(cols) + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/char_screen_buffer_if.sv
// Writer/renderer bus of the character screen buffer.
interface char_screen_buffer_if;
    import char_buf_pkg::*;

    logic               wr_en;
    logic [GLYPH_W-1:0] wr_glyph;
    logic [ROW_W-1:0]   wr_row;
    logic [COL_W-1:0]   wr_col;
    logic               clr;
    logic               full;
    logic [ROW_W-1:0]   rd_row;
    logic [COL_W-1:0]   rd_col;
    logic [GLYPH_W-1:0] rd_glyph;
    logic               busy;
    logic               range_err;
    logic               drop_err;

    modport master (
        output wr_en, wr_glyph, wr_row, wr_col, clr, full, rd_row, rd_col,
        input  rd_glyph, busy, range_err, drop_err
    );

    modport slave (
        input  wr_en, wr_glyph, wr_row, wr_col, clr, full, rd_row, rd_col,
        output rd_glyph, busy, range_err, drop_err
    );

endinterface

// File: rtl/char_buf_ram.sv
// Cell storage: one write port, one registered read-before-write read port with forced-glyph override.
module char_buf_ram
    import char_buf_pkg::*;
#(
    parameter int unsigned        DEPTH     = CELLS,
    parameter logic [GLYPH_W-1:0] RST_GLYPH = BLANK_GLYPH
) (
    input  logic               clk,
    input  logic               reset_n,
    input  ram_wr_t            wr,
    input  logic [ADDR_W-1:0]  rd_addr,
    input  logic               rd_force,
    output logic [GLYPH_W-1:0] rd_glyph
);

    logic [GLYPH_W-1:0] mem [DEPTH];

    // Storage has no reset; the clear sweep initialises it.
    always_ff @(posedge clk) begin
        if (wr.we) begin
            mem[wr.addr] <= wr.data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_glyph <= RST_GLYPH;
        end else begin
            rd_glyph <= rd_force ? RST_GLYPH : mem[rd_addr];
        end
    end

endmodule

// File: rtl/char_screen_buffer.sv
// Character screen buffer with self-clearing sweep; define CHAR_BUF_AUTOCLR_EN to let a full pulse start a clear.
module char_screen_buffer
    import char_buf_pkg::*;
#(
    parameter int unsigned        ROWS  = ROWS_DEF,
    parameter int unsigned        COLS  = COLS_DEF,
    parameter logic [GLYPH_W-1:0] BLANK = BLANK_GLYPH
) (
    input logic                 clk,
    input logic                 reset_n,
    char_screen_buffer_if.slave bus
);

    localparam int unsigned       NCELLS    = ROWS * COLS;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NCELLS - 1);

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  sweep_addr, sweep_addr_nxt;
    logic               sweep_we, busy_nxt;
    logic               busy_q, range_err_q, drop_err_q;
    logic               clr_req, wr_valid, wr_in_range, wr_accept, rd_in_range;
    logic [ADDR_W-1:0]  wr_addr, rd_addr;
    logic [GLYPH_W-1:0] rd_q;
    ram_wr_t            ram_wr;

`ifdef CHAR_BUF_AUTOCLR_EN
    assign clr_req = bus.clr | bus.full;
`else
    logic unused_full;
    assign unused_full = bus.full;
    assign clr_req     = bus.clr;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_req) state_nxt = CLEAR;
            CLEAR:   if (!clr_req && (sweep_addr == LAST_ADDR)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A clear request during the sweep rewinds it to address 0.
    always_comb begin
        sweep_we       = 1'b0;
        sweep_addr_nxt = sweep_addr;
        busy_nxt       = (state_nxt == CLEAR);
        case (state)
            IDLE: sweep_addr_nxt = '0;
            CLEAR: begin
                sweep_we = 1'b1;
                if (clr_req || (sweep_addr == LAST_ADDR)) begin
                    sweep_addr_nxt = '0;
                end else begin
                    sweep_addr_nxt = sweep_addr + ADDR_W'(1);
                end
            end
            default: sweep_addr_nxt = '0;
        endcase
    end

    assign wr_valid    = bus.wr_en && (bus.wr_glyph != CLR_GLYPH);
    assign wr_in_range = (bus.wr_row < ROW_W'(ROWS)) && (bus.wr_col < COL_W'(COLS));
    assign wr_accept   = wr_valid && wr_in_range && !busy_q && !clr_req;
    assign wr_addr     = wr_in_range ? cell_addr(bus.wr_row, bus.wr_col, COLS) : '0;
    assign rd_in_range = (bus.rd_row < ROW_W'(ROWS)) && (bus.rd_col < COL_W'(COLS));
    assign rd_addr     = rd_in_range ? cell_addr(bus.rd_row, bus.rd_col, COLS) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sweep_addr  <= '0;
            busy_q      <= 1'b1;
            range_err_q <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            sweep_addr <= sweep_addr_nxt;
            busy_q     <= busy_nxt;
            if (wr_valid && !wr_in_range)         range_err_q <= 1'b1;
            if (wr_valid && (busy_q || clr_req))  drop_err_q  <= 1'b1;
        end
    end

    // Sweep and user writes are mutually exclusive: user writes only land while idle.
    always_comb begin
        ram_wr.we   = sweep_we | wr_accept;
        ram_wr.addr = sweep_we ? sweep_addr : wr_addr;
        ram_wr.data = sweep_we ? BLANK : bus.wr_glyph;
    end

    char_buf_ram #(
        .DEPTH     (NCELLS),
        .RST_GLYPH (BLANK)
    ) u_ram (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr       (ram_wr),
        .rd_addr  (rd_addr),
        .rd_force (busy_q || !rd_in_range),
        .rd_glyph (rd_q)
    );

    assign bus.rd_glyph  = rd_q;
    assign bus.busy      = busy_q;
    assign bus.range_err = range_err_q;
    assign bus.drop_err  = drop_err_q;

endmodule

// File: tb/tb_char_screen_buffer.sv
// Directed bench for char_screen_buffer with a read scoreboard and a shadow cell model.
module tb_char_screen_buffer;

    localparam int NROWS = 7;
    localparam int NCOLS = 20;
    localparam int NCELL = NROWS * NCOLS;
    localparam logic [7:0] BLK = 8'd128;

    logic clk;
    logic reset_n;
    int   cyc;
    int   n_cmp;
    int   n_err;
    int   n;
    int   t0;
    int   t1;
    logic [7:0] model [NCELL];
    logic [7:0] exp_q [$];

    char_screen_buffer_if bus ();

    char_screen_buffer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic rd_check(input int r, input int c, input logic [7:0] exp, input string tag);
        logic [7:0] e;
        bus.rd_row = 4'(r);
        bus.rd_col = 6'(c);
        exp_q.push_back(exp);
        tick();
        e = exp_q.pop_front();
        check(tag, 32'(bus.rd_glyph), 32'(e));
    endtask

    function automatic logic [7:0] model_at(input int r, input int c);
        if (r < NROWS && c < NCOLS) return model[r * NCOLS + c];
        return BLK;
    endfunction

    task automatic rd_model(input int r, input int c, input string tag);
        rd_check(r, c, model_at(r, c), tag);
    endtask

    task automatic write(input int r, input int c, input logic [7:0] g);
        bus.wr_en    = 1'b1;
        bus.wr_row   = 4'(r);
        bus.wr_col   = 6'(c);
        bus.wr_glyph = g;
        tick();
        bus.wr_en    = 1'b0;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 400) begin
            tick();
            cnt++;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NCELL; i++) model[i] = BLK;
    endtask

    initial begin
        cyc = 0; n_cmp = 0; n_err = 0;
        reset_n = 1'b0;
        bus.wr_en = 1'b0; bus.wr_glyph = 8'd0; bus.wr_row = 4'd0; bus.wr_col = 6'd0;
        bus.clr = 1'b0; bus.full = 1'b0; bus.rd_row = 4'd0; bus.rd_col = 6'd0;
        repeat (3) tick();

        check("rst_rd_glyph", 32'(bus.rd_glyph), 32'(BLK));
        check("rst_busy", 32'(bus.busy), 32'd1);
        check("rst_range_err", 32'(bus.range_err), 32'd0);
        check("rst_drop_err", 32'(bus.drop_err), 32'd0);

        reset_n = 1'b1;
        wait_idle(n);
        check("rst_sweep_len", 32'(n), 32'd140);
        model_clear();
        for (int r = 0; r < NROWS; r++)
            for (int c = 0; c < NCOLS; c++)
                rd_model(r, c, "init_blank");

        write(2, 5, 8'd10);
        model[2 * NCOLS + 5] = 8'd10;
        rd_model(2, 5, "wr_2_5");
        rd_model(2, 6, "nbr_2_6");

        // Read and write of the same cell in one cycle returns the old glyph.
        bus.wr_en = 1'b1; bus.wr_row = 4'd3; bus.wr_col = 6'd3; bus.wr_glyph = 8'd33;
        rd_check(3, 3, BLK, "rbw_old");
        bus.wr_en = 1'b0;
        model[3 * NCOLS + 3] = 8'd33;
        rd_model(3, 3, "rbw_new");
        write(6, 19, 8'd250);
        model[NCELL - 1] = 8'd250;
        rd_model(6, 19, "wr_last_cell");

        write(1, 1, 8'hFF);
        rd_model(1, 1, "ff_ignored");
        check("ff_no_range_err", 32'(bus.range_err), 32'd0);
        check("ff_no_drop_err", 32'(bus.drop_err), 32'd0);

        write(7, 0, 8'd55);
        check("range_row7", 32'(bus.range_err), 32'd1);
        rd_model(7, 0, "rd_oor_row");
        rd_model(0, 0, "oor_unchanged_0_0");
        write(0, 20, 8'd56);
        rd_model(0, 20, "rd_oor_col");
        rd_model(1, 0, "oor_unchanged_1_0");
        repeat (5) tick();
        check("range_sticky", 32'(bus.range_err), 32'd1);
        check("range_no_drop", 32'(bus.drop_err), 32'd0);

        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        t0 = cyc;
        check("clr_busy", 32'(bus.busy), 32'd1);
        rd_check(2, 5, BLK, "rd_while_busy");
        write(0, 0, 8'd77);
        check("drop_err_set", 32'(bus.drop_err), 32'd1);
        wait_idle(n);
        check("clr_sweep_len", 32'(cyc - t0), 32'd140);
        model_clear();
        rd_model(0, 0, "dropped_cell");
        rd_model(2, 5, "cleared_2_5");
        rd_model(6, 19, "cleared_last");
        check("drop_sticky", 32'(bus.drop_err), 32'd1);

        write(4, 4, 8'd99);
        model[4 * NCOLS + 4] = 8'd99;
        rd_model(4, 4, "pre_full");
        bus.full = 1'b1;
        tick();
        bus.full = 1'b0;
`ifdef CHAR_BUF_AUTOCLR_EN
        t0 = cyc;
        check("full_busy", 32'(bus.busy), 32'd1);
        wait_idle(n);
        check("full_sweep_len", 32'(cyc - t0), 32'd140);
        model_clear();
`else
        check("full_no_busy", 32'(bus.busy), 32'd0);
        repeat (10) tick();
        check("full_still_idle", 32'(bus.busy), 32'd0);
`endif
        rd_model(4, 4, "post_full");

        write(5, 7, 8'd44);
        model[5 * NCOLS + 7] = 8'd44;
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        t0 = cyc;
        repeat (70) tick();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        t1 = cyc;
        check("restart_gap", 32'(t1 - t0), 32'd71);
        check("restart_busy", 32'(bus.busy), 32'd1);
        repeat (100) tick();
        check("restart_busy_mid", 32'(bus.busy), 32'd1);
        wait_idle(n);
        check("restart_sweep_len", 32'(cyc - t1), 32'd140);
        model_clear();
        rd_model(5, 7, "restart_cleared");
        rd_model(0, 0, "restart_first");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
